cat_draw: RTL and testbench

//  Reading end of the cat sprite ROM port (4 frames x 64x64, 12-bit RGB, 1-cycle registered read).

---
 rtl/cat_draw.sv | 131 +++++++++++++
 tb/tb_cat_draw.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cat_draw.sv
// Cat sprite overlay for the VGA pixel pipeline: ROM addressing, frame select, colour keying and
// the vsync-driven walk-animation sequencer. Every stream signal leaves exactly 2 cycles after entry.
module cat_draw #(
    parameter int          SPR_W     = 64,
    parameter int          SPR_H     = 64,
    parameter logic [11:0] TRANSP    = 12'hF0F,
    parameter int          FRAME_DIV = 8
) (
    input  logic                                     clk60MHz,
    input  logic                                     rst,
    input  logic [10:0]                              hcount_in,
    input  logic [10:0]                              vcount_in,
    input  logic                                     hsync_in,
    input  logic                                     hblnk_in,
    input  logic                                     vsync_in,
    input  logic                                     vblnk_in,
    input  logic [11:0]                              rgb_in,
    input  logic [11:0]                              xpos,
    input  logic [11:0]                              ypos,
    input  logic                                     anim_en,
    output logic [$clog2(SPR_H)+$clog2(SPR_W)-1:0]   rom_addr,
    input  logic [11:0]                              rom_rgb0,
    input  logic [11:0]                              rom_rgb1,
    input  logic [11:0]                              rom_rgb2,
    input  logic [11:0]                              rom_rgb3,
    output logic [1:0]                               frame_idx,
    output logic [10:0]                              hcount_out,
    output logic [10:0]                              vcount_out,
    output logic                                     hsync_out,
    output logic                                     hblnk_out,
    output logic                                     vsync_out,
    output logic                                     vblnk_out,
    output logic [11:0]                              rgb_out
);

    localparam int AX    = $clog2(SPR_W);
    localparam int AY    = $clog2(SPR_H);
    localparam int AW    = AX + AY;
    localparam int DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [11:0]      SPR_W12  = 12'(SPR_W);
    localparam logic [11:0]      SPR_H12  = 12'(SPR_H);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

    // Timing bundle: {hcount, vcount, hsync, hblnk, vsync, vblnk}
    localparam int TW = 26;

    logic [TW-1:0]    tim_in;
    logic [TW-1:0]    tim_s1_q, tim_s2_q;
    logic [11:0]      rgb_s1_q, rgb_s1_d;
    logic             in_s1_q, in_s1_d;
    logic [AW-1:0]    rom_addr_q, rom_addr_d;
    logic [11:0]      rgb_out_q, rgb_out_d;
    logic             vsync_prev_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       frame_q, frame_d;

    logic [11:0]      dx, dy;
    logic [11:0]      pix;
    logic             vs_edge;

    assign tim_in = {hcount_in, vcount_in, hsync_in, hblnk_in, vsync_in, vblnk_in};

    always_comb begin
        // Stage 1: sprite-relative coordinates; wrap makes left/above positions huge, hence outside.
        dx         = {1'b0, hcount_in} - xpos;
        dy         = {1'b0, vcount_in} - ypos;
        in_s1_d    = (dx < SPR_W12) && (dy < SPR_H12) && !hblnk_in && !vblnk_in;
        rom_addr_d = in_s1_d ? {dy[AY-1:0], dx[AX-1:0]} : '0;
        rgb_s1_d   = rgb_in;

        // Stage 2: ROM data for the address registered in stage 1 is present now.
        case (frame_q)
            2'd0:    pix = rom_rgb0;
            2'd1:    pix = rom_rgb1;
            2'd2:    pix = rom_rgb2;
            default: pix = rom_rgb3;
        endcase
        rgb_out_d = (in_s1_q && (pix != TRANSP)) ? pix : rgb_s1_q;

        // Frame changes only on a vsync rising edge, so a visible frame never tears.
        vs_edge = vsync_in && !vsync_prev_q;
        div_d   = div_q;
        frame_d = frame_q;
        if (vs_edge) begin
            if (!anim_en) begin
                div_d   = '0;
                frame_d = 2'd0;
            end else if (div_q == DIV_LAST) begin
                div_d   = '0;
                frame_d = frame_q + 2'd1;
            end else begin
                div_d   = div_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk60MHz or posedge rst) begin
        if (rst) begin
            tim_s1_q     <= '0;
            rgb_s1_q     <= '0;
            in_s1_q      <= 1'b0;
            rom_addr_q   <= '0;
            tim_s2_q     <= '0;
            rgb_out_q    <= '0;
            vsync_prev_q <= 1'b0;
            div_q        <= '0;
            frame_q      <= 2'd0;
        end else begin
            tim_s1_q     <= tim_in;
            rgb_s1_q     <= rgb_s1_d;
            in_s1_q      <= in_s1_d;
            rom_addr_q   <= rom_addr_d;
            tim_s2_q     <= tim_s1_q;
            rgb_out_q    <= rgb_out_d;
            vsync_prev_q <= vsync_in;
            div_q        <= div_d;
            frame_q      <= frame_d;
        end
    end

    assign rom_addr   = rom_addr_q;
    assign frame_idx  = frame_q;
    assign rgb_out    = rgb_out_q;
    assign hcount_out = tim_s2_q[25:15];
    assign vcount_out = tim_s2_q[14:4];
    assign hsync_out  = tim_s2_q[3];
    assign hblnk_out  = tim_s2_q[2];
    assign vsync_out  = tim_s2_q[1];
    assign vblnk_out  = tim_s2_q[0];

endmodule

// File: tb/tb_cat_draw.sv
// Directed bench for cat_draw: reset, addressing, keying, clipping and the animation sequencer.
module tb_cat_draw;

    logic        clk60MHz = 1'b0;
    logic        rst;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
    logic [11:0] rgb_in, xpos, ypos;
    logic        anim_en;
    logic [11:0] rom_addr;
    logic [11:0] rom_rgb0, rom_rgb1, rom_rgb2, rom_rgb3;
    logic [1:0]  frame_idx;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
    logic [11:0] rgb_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #8 clk60MHz = ~clk60MHz;

    // ROM model: frame 0 returns its own address, other frames a distinct XOR of it.
    assign rom_rgb0 = rom_addr;
    assign rom_rgb1 = rom_addr ^ 12'h111;
    assign rom_rgb2 = rom_addr ^ 12'h222;
    assign rom_rgb3 = rom_addr ^ 12'h333;

    cat_draw dut (
        .clk60MHz  (clk60MHz),
        .rst       (rst),
        .hcount_in (hcount_in),
        .vcount_in (vcount_in),
        .hsync_in  (hsync_in),
        .hblnk_in  (hblnk_in),
        .vsync_in  (vsync_in),
        .vblnk_in  (vblnk_in),
        .rgb_in    (rgb_in),
        .xpos      (xpos),
        .ypos      (ypos),
        .anim_en   (anim_en),
        .rom_addr  (rom_addr),
        .rom_rgb0  (rom_rgb0),
        .rom_rgb1  (rom_rgb1),
        .rom_rgb2  (rom_rgb2),
        .rom_rgb3  (rom_rgb3),
        .frame_idx (frame_idx),
        .hcount_out(hcount_out),
        .vcount_out(vcount_out),
        .hsync_out (hsync_out),
        .hblnk_out (hblnk_out),
        .vsync_out (vsync_out),
        .vblnk_out (vblnk_out),
        .rgb_out   (rgb_out)
    );

    task automatic drive(input logic [10:0] h, input logic [10:0] v, input logic hb,
                         input logic [11:0] rgb);
        hcount_in = h;
        vcount_in = v;
        hblnk_in  = hb;
        rgb_in    = rgb;
    endtask

    task automatic test_reset;
        xpos = 12'd100; ypos = 12'd50;
        drive(11'd120, 11'd60, 1'b0, 12'h456);
        hsync_in = 1'b1;
        repeat (3) @(negedge clk60MHz);
        #3 rst = 1'b1;
        #1;
        n_checks++;
        if ({rgb_out, rom_addr, hcount_out, vcount_out, hsync_out, frame_idx} !== '0) begin
            n_fail++;
            $display("FAIL reset_async: rgb=%h addr=%h hcnt=%0d hs=%b expected all 0",
                     rgb_out, rom_addr, hcount_out, hsync_out);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk60MHz);
            n_checks++;
            if (rgb_out !== 12'h000 || rom_addr !== 12'h000 || hcount_out !== 11'd0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: rgb=%h addr=%h hcnt=%0d expected 0", i,
                         rgb_out, rom_addr, hcount_out);
            end
        end
        rst = 1'b0;
        @(negedge clk60MHz);
        n_checks++;
        if (rgb_out !== 12'h000 || rom_addr !== 12'h294) begin
            n_fail++;
            $display("FAIL reset_refill1: rgb=%h addr=%h expected rgb 000 addr 294", rgb_out, rom_addr);
        end
        @(negedge clk60MHz);
        n_checks++;
        if (rgb_out !== 12'h294 || hcount_out !== 11'd120 || hsync_out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_refill2: rgb=%h hcnt=%0d hs=%b expected 294 120 1",
                     rgb_out, hcount_out, hsync_out);
        end
        hsync_in = 1'b0;
    endtask

    task automatic test_address;
        xpos = 12'd100; ypos = 12'd50;
        drive(11'd163, 11'd113, 1'b0, 12'h777);
        @(negedge clk60MHz);
        n_checks++;
        if (rom_addr !== 12'hFFF) begin
            n_fail++;
            $display("FAIL addr_corner: got %h expected fff", rom_addr);
        end
        @(negedge clk60MHz);
        n_checks++;
        if (rgb_out !== 12'hFFF || hcount_out !== 11'd163 || vcount_out !== 11'd113) begin
            n_fail++;
            $display("FAIL pix_corner: rgb=%h h=%0d v=%0d expected fff 163 113",
                     rgb_out, hcount_out, vcount_out);
        end
        drive(11'd164, 11'd113, 1'b0, 12'h777);
        @(negedge clk60MHz);
        n_checks++;
        if (rom_addr !== 12'h000) begin
            n_fail++;
            $display("FAIL addr_right_out: got %h expected 000", rom_addr);
        end
        @(negedge clk60MHz);
        n_checks++;
        if (rgb_out !== 12'h777) begin
            n_fail++;
            $display("FAIL pix_right_out: got %h expected 777", rgb_out);
        end
        drive(11'd99, 11'd60, 1'b0, 12'h0AA);
        repeat (2) @(negedge clk60MHz);
        n_checks++;
        if (rgb_out !== 12'h0AA || rom_addr !== 12'h000) begin
            n_fail++;
            $display("FAIL pix_left_out: rgb=%h addr=%h expected 0aa 000", rgb_out, rom_addr);
        end
    endtask

    task automatic test_transparency;
        xpos = 12'd100; ypos = 12'd50;
        // dy=60, dx=15 gives address f0f, which the ROM returns as the transparent colour
        drive(11'd115, 11'd110, 1'b0, 12'h123);
        repeat (2) @(negedge clk60MHz);
        n_checks++;
        if (rgb_out !== 12'h123) begin
            n_fail++;
            $display("FAIL transp_key: got %h expected 123", rgb_out);
        end
        // dy=42, dx=60 gives address abc
        drive(11'd160, 11'd92, 1'b0, 12'h123);
        repeat (2) @(negedge clk60MHz);
        n_checks++;
        if (rgb_out !== 12'hABC) begin
            n_fail++;
            $display("FAIL opaque_pix: got %h expected abc", rgb_out);
        end
    endtask

    task automatic test_clipping;
        xpos = 12'hFF0; ypos = 12'd50;
        drive(11'd5, 11'd60, 1'b0, 12'h0B0);
        @(negedge clk60MHz);
        n_checks++;
        if (rom_addr !== 12'h295) begin
            n_fail++;
            $display("FAIL clip_left_addr: got %h expected 295", rom_addr);
        end
        drive(11'd48, 11'd60, 1'b0, 12'h0B0);
        repeat (2) @(negedge clk60MHz);
        n_checks++;
        if (rgb_out !== 12'h0B0 || rom_addr !== 12'h000) begin
            n_fail++;
            $display("FAIL clip_left_end: rgb=%h addr=%h expected 0b0 000", rgb_out, rom_addr);
        end
        xpos = 12'd620;
        drive(11'd639, 11'd60, 1'b0, 12'h0C0);
        repeat (2) @(negedge clk60MHz);
        n_checks++;
        if (rgb_out !== 12'h293 || hblnk_out !== 1'b0) begin
            n_fail++;
            $display("FAIL clip_right_vis: rgb=%h hb=%b expected 293 0", rgb_out, hblnk_out);
        end
        drive(11'd640, 11'd60, 1'b1, 12'h0C0);
        @(negedge clk60MHz);
        n_checks++;
        if (rom_addr !== 12'h000) begin
            n_fail++;
            $display("FAIL clip_blank_addr: got %h expected 000", rom_addr);
        end
        @(negedge clk60MHz);
        n_checks++;
        if (rgb_out !== 12'h0C0 || hblnk_out !== 1'b1) begin
            n_fail++;
            $display("FAIL clip_blank_pix: rgb=%h hb=%b expected 0c0 1", rgb_out, hblnk_out);
        end
        hblnk_in = 1'b0;
    endtask

    task automatic vsync_pulse;
        vsync_in = 1'b1;
        @(negedge clk60MHz);
        vsync_in = 1'b0;
        @(negedge clk60MHz);
    endtask

    task automatic test_animation;
        logic [1:0] exp_frame;
        anim_en = 1'b1;
        for (int e = 1; e <= 40; e++) begin
            vsync_pulse();
            exp_frame = 2'((e / 8) % 4);
            n_checks++;
            if (frame_idx !== exp_frame) begin
                n_fail++;
                $display("FAIL anim_edge%0d: frame=%0d expected %0d", e, frame_idx, exp_frame);
            end
        end
        xpos = 12'd100; ypos = 12'd50;
        drive(11'd120, 11'd60, 1'b0, 12'h000);
        repeat (2) @(negedge clk60MHz);
        n_checks++;
        if (rgb_out !== 12'h385) begin
            n_fail++;
            $display("FAIL anim_frame1_pix: got %h expected 385", rgb_out);
        end
    endtask

    task automatic test_anim_drop;
        for (int e = 0; e < 8; e++) vsync_pulse();
        n_checks++;
        if (frame_idx !== 2'd2) begin
            n_fail++;
            $display("FAIL drop_pre: frame=%0d expected 2", frame_idx);
        end
        anim_en = 1'b0;
        repeat (4) @(negedge clk60MHz);
        n_checks++;
        if (frame_idx !== 2'd2) begin
            n_fail++;
            $display("FAIL drop_hold: frame=%0d expected 2", frame_idx);
        end
        repeat (2) @(negedge clk60MHz);
        n_checks++;
        if (rgb_out !== 12'h0B6) begin
            n_fail++;
            $display("FAIL drop_frame2_pix: got %h expected 0b6", rgb_out);
        end
        vsync_pulse();
        n_checks++;
        if (frame_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL drop_edge: frame=%0d expected 0", frame_idx);
        end
        // Re-enable: divider must have restarted, so 7 edges leave frame 0 and the 8th steps it
        anim_en = 1'b1;
        for (int e = 0; e < 7; e++) vsync_pulse();
        n_checks++;
        if (frame_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL reenable_7: frame=%0d expected 0", frame_idx);
        end
        vsync_pulse();
        n_checks++;
        if (frame_idx !== 2'd1) begin
            n_fail++;
            $display("FAIL reenable_8: frame=%0d expected 1", frame_idx);
        end
        // anim_en falling on the same cycle as the vsync edge forces frame 0
        anim_en = 1'b0;
        vsync_pulse();
        n_checks++;
        if (frame_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL simul_drop: frame=%0d expected 0", frame_idx);
        end
    endtask

    initial begin
        rst = 1'b1;
        hcount_in = '0; vcount_in = '0;
        hsync_in = 1'b0; hblnk_in = 1'b0; vsync_in = 1'b0; vblnk_in = 1'b0;
        rgb_in = '0; xpos = '0; ypos = '0; anim_en = 1'b0;
        repeat (3) @(negedge clk60MHz);
        rst = 1'b0;
        @(negedge clk60MHz);
        test_reset();
        test_address();
        test_transparency();
        test_clipping();
        test_animation();
        test_anim_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
